// File: rtl/memory_responder_if.sv
// Request/response bundle between a CPU-side requester and memory_responder.
// Pure wiring, no latency; no backpressure (requests are held for a fixed window).
// The bidirectional data2 bus stays a module-level net so tristate resolution happens on one wire.
interface memory_responder_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8
);
    logic                 readM1;
    logic [WORD_SIZE-1:0] address1;
    logic [WORD_SIZE-1:0] data1;
    logic                 readM2;
    logic                 writeM2;
    logic [WORD_SIZE-1:0] address2;
    logic                 data2_oe;
    logic                 load_en;
    logic [ADDR_BITS-1:0] load_addr;
    logic [WORD_SIZE-1:0] load_data;
    logic [WORD_SIZE-1:0] inst_reads;
    logic [WORD_SIZE-1:0] data_reads;
    logic [WORD_SIZE-1:0] data_writes;
    logic                 proto_err;

    modport master (
        output readM1, address1, readM2, writeM2, address2,
               load_en, load_addr, load_data,
        input  data1, data2_oe, inst_reads, data_reads, data_writes, proto_err
    );

    modport slave (
        input  readM1, address1, readM2, writeM2, address2,
               load_en, load_addr, load_data,
        output data1, data2_oe, inst_reads, data_reads, data_writes, proto_err
    );
endinterface

// File: rtl/memory_responder.sv
// Dual-port word memory: registered instruction fetch port plus a tristate read/write data port.
// Reads return data 1 cycle after the request edge; writes commit on the request edge.
// No backpressure: every request present at a posedge is accepted, dropped or flagged.
module memory_responder #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    memory_responder_if.slave    bus,
    inout  wire  [WORD_SIZE-1:0] data2
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [WORD_SIZE-1:0] data1_q;
    logic [WORD_SIZE-1:0] rd2_q;
    logic [WORD_SIZE-1:0] inst_q;
    logic [WORD_SIZE-1:0] drd_q;
    logic [WORD_SIZE-1:0] dwr_q;
    logic                 err_q;

    logic [ADDR_BITS-1:0] idx1;
    logic [ADDR_BITS-1:0] idx2;

    logic drive2;
    logic rd2_acc;
    logic wr2_req;
    logic wr2_commit;
    logic err_set;

    // Upper address bits alias onto the same array; they are intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.address1[WORD_SIZE-1:ADDR_BITS],
                              bus.address2[WORD_SIZE-1:ADDR_BITS]};

    assign idx1 = bus.address1[ADDR_BITS-1:0];
    assign idx2 = bus.address2[ADDR_BITS-1:0];

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case ({bus.readM2, bus.writeM2})
            2'b10:   state_d = S_RD;
            2'b01:   state_d = S_WR;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        drive2     = (state_q == S_RD) && bus.readM2 && !bus.writeM2;
        rd2_acc    = (state_d == S_RD);
        wr2_req    = (state_d == S_WR);
        // A write still pending while reset is held low is abandoned.
        wr2_commit = wr2_req && !bus.load_en && Reset_N;
        err_set    = (bus.readM2 && bus.writeM2) || (wr2_req && bus.load_en);
    end

    // Array has no reset so preloaded contents survive Reset_N.
    always_ff @(posedge Clk) begin
        if (bus.load_en) begin
            mem[bus.load_addr] <= bus.load_data;
        end else if (wr2_commit) begin
            mem[idx2] <= data2;
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            data1_q <= '0;
            rd2_q   <= '0;
            inst_q  <= '0;
            drd_q   <= '0;
            dwr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (bus.readM1) begin
                data1_q <= mem[idx1];
                inst_q  <= inst_q + WORD_SIZE'(1);
            end
            if (rd2_acc) begin
                rd2_q <= mem[idx2];
                drd_q <= drd_q + WORD_SIZE'(1);
            end
            if (wr2_commit) begin
                dwr_q <= dwr_q + WORD_SIZE'(1);
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign data2 = drive2 ? rd2_q : {WORD_SIZE{1'bz}};

    assign bus.data1       = data1_q;
    assign bus.data2_oe    = drive2;
    assign bus.inst_reads  = inst_q;
    assign bus.data_reads  = drd_q;
    assign bus.data_writes = dwr_q;
    assign bus.proto_err   = err_q;
endmodule

// File: tb/tb_memory_responder.sv
// Directed and randomized bench for memory_responder against an array/counter reference model.
module tb_memory_responder;
    localparam int W = 16;
    localparam int A = 8;

    logic         Clk = 1'b0;
    logic         Reset_N;
    wire  [W-1:0] data2;
    logic [W-1:0] d2_drv;
    logic         d2_en;

    assign data2 = d2_en ? d2_drv : {W{1'bz}};

    memory_responder_if #(.WORD_SIZE(W), .ADDR_BITS(A)) bus ();

    memory_responder #(.WORD_SIZE(W), .ADDR_BITS(A)) dut (
        .Clk    (Clk),
        .Reset_N(Reset_N),
        .bus    (bus),
        .data2  (data2)
    );

    always #5 Clk = ~Clk;

    // Reference model state
    logic [W-1:0] m_mem [256];
    logic [W-1:0] e_data1, e_rd2, e_ir, e_dr, e_dw;
    logic         e_err, e_rd;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_data1 = '0; e_rd2 = '0; e_ir = '0; e_dr = '0; e_dw = '0;
        e_err = 1'b0; e_rd = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic oe;
        oe = e_rd && bus.readM2 && !bus.writeM2;
        chk({tag, ".data1"},       bus.data1,       e_data1);
        chk({tag, ".inst_reads"},  bus.inst_reads,  e_ir);
        chk({tag, ".data_reads"},  bus.data_reads,  e_dr);
        chk({tag, ".data_writes"}, bus.data_writes, e_dw);
        chk({tag, ".proto_err"},   W'(bus.proto_err), W'(e_err));
        chk({tag, ".data2_oe"},    W'(bus.data2_oe),  W'(oe));
        if (oe) chk({tag, ".data2"}, data2, e_rd2);
    endtask

    // Apply one cycle of requests, advance the model by the access rules, check after the edge.
    task automatic step(input string tag,
                        input logic r1, input logic [W-1:0] a1,
                        input logic r2, input logic w2,
                        input logic [W-1:0] a2, input logic [W-1:0] wd,
                        input logic le, input logic [A-1:0] la, input logic [W-1:0] ld);
        logic rd_ok, wr_ok;
        bus.readM1 = r1; bus.address1 = a1;
        bus.readM2 = r2; bus.writeM2 = w2; bus.address2 = a2;
        bus.load_en = le; bus.load_addr = la; bus.load_data = ld;
        d2_en = w2; d2_drv = wd;
        if (Reset_N) begin
            rd_ok = r2 && !w2;
            wr_ok = w2 && !r2;
            if (r1) begin e_data1 = m_mem[a1[7:0]]; e_ir = e_ir + 1'b1; end
            if (rd_ok) begin e_rd2 = m_mem[a2[7:0]]; e_dr = e_dr + 1'b1; end
            e_rd = rd_ok;
            if (r2 && w2) e_err = 1'b1;
            if (wr_ok && le) e_err = 1'b1;
            if (le) m_mem[la] = ld;
            else if (wr_ok) begin m_mem[a2[7:0]] = wd; e_dw = e_dw + 1'b1; end
        end
        @(posedge Clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 8'h0, 16'h0);
    endtask

    task automatic reset_between_edges(input string tag);
        #2;
        Reset_N = 1'b0;
        model_reset();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [W-1:0] saved;
        Reset_N = 1'b0;
        bus.readM1 = 0; bus.address1 = '0; bus.readM2 = 0; bus.writeM2 = 0;
        bus.address2 = '0; bus.load_en = 0; bus.load_addr = '0; bus.load_data = '0;
        d2_en = 0; d2_drv = '0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge Clk);
        Reset_N = 1'b1;

        // Preload the whole array; a load alone must not move any counter.
        for (int i = 0; i < 256; i++)
            step("preload", 0, 16'h0, 0, 0, 16'h0, 16'h0, 1, A'(i), W'($urandom));
        for (int i = 0; i < 4; i++)
            step("preload_prog", 0, 16'h0, 0, 0, 16'h0, 16'h0, 1, A'(i), 16'h1001 + W'(i));

        // Instruction fetch
        for (int i = 0; i < 4; i++) begin
            step("fetch", 1, W'(i), 0, 0, 16'h0, 16'h0, 0, 8'h0, 16'h0);
            chk("fetch_value", bus.data1, 16'h1001 + W'(i));
        end
        chk("fetch_count", bus.inst_reads, 16'd4);

        // Write then read on the data port
        step("wr_beef", 0, 16'h0, 0, 1, 16'h0010, 16'hBEEF, 0, 8'h0, 16'h0);
        chk("wr_no_drive", W'(bus.data2_oe), 16'd0);
        step("rd_beef", 0, 16'h0, 1, 0, 16'h0010, 16'h0, 0, 8'h0, 16'h0);
        chk("rd_drive", W'(bus.data2_oe), 16'd1);
        chk("rd_value", data2, 16'hBEEF);
        chk("rd_writes", bus.data_writes, 16'd1);
        chk("rd_reads", bus.data_reads, 16'd1);

        // Aliasing and read-before-write
        step("load5", 0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 8'h05, 16'h0001);
        step("rbw", 1, 16'h0005, 0, 1, 16'h0105, 16'h0002, 0, 8'h0, 16'h0);
        chk("rbw_old", bus.data1, 16'h0001);
        step("rbw_new", 1, 16'h0005, 0, 0, 16'h0, 16'h0, 0, 8'h0, 16'h0);
        chk("rbw_new_val", bus.data1, 16'h0002);

        // Illegal read+write, then load priority over a write
        saved = e_dw;
        step("illegal", 0, 16'h0, 1, 1, 16'h0007, 16'h1234, 0, 8'h0, 16'h0);
        chk("illegal_err", W'(bus.proto_err), 16'd1);
        step("illegal_chk", 1, 16'h0007, 0, 0, 16'h0, 16'h0, 0, 8'h0, 16'h0);
        step("prio", 0, 16'h0, 0, 1, 16'h0009, 16'hAAAA, 1, 8'h09, 16'h5555);
        step("prio_chk", 1, 16'h0009, 0, 0, 16'h0, 16'h0, 0, 8'h0, 16'h0);
        chk("prio_value", bus.data1, 16'h5555);
        chk("prio_writes", bus.data_writes, saved);

        // Async reset while driving a read, then an abandoned write under reset
        step("pre_rst_rd", 0, 16'h0, 1, 0, 16'h0010, 16'h0, 0, 8'h0, 16'h0);
        chk("pre_rst_drive", W'(bus.data2_oe), 16'd1);
        reset_between_edges("async_rst");
        step("wr_in_rst", 0, 16'h0, 0, 1, 16'h0021, 16'hDEAD, 0, 8'h0, 16'h0);
        @(negedge Clk);
        Reset_N = 1'b1;
        step("post_rst_21", 1, 16'h0021, 0, 0, 16'h0, 16'h0, 0, 8'h0, 16'h0);
        step("post_rst_10", 1, 16'h0010, 0, 0, 16'h0, 16'h0, 0, 8'h0, 16'h0);
        chk("survive_beef", bus.data1, 16'hBEEF);

        // Randomized traffic with aliasing and index collisions
        for (int n = 0; n < 400; n++) begin
            int op;
            logic r2, w2;
            op = $urandom_range(0, 7);
            r2 = (op <= 2) || (op == 7);
            w2 = (op >= 3 && op <= 5) || (op == 7);
            step("rand", 1'($urandom), {8'($urandom_range(0, 3)), 8'($urandom_range(0, 15))},
                 r2, w2, {8'($urandom_range(0, 3)), 8'($urandom_range(0, 15))}, W'($urandom),
                 ($urandom_range(0, 9) == 0), A'($urandom_range(0, 15)), W'($urandom));
        end
        idle("rand_end");

        // Counter wrap
        reset_between_edges("wrap_rst");
        @(negedge Clk);
        Reset_N = 1'b1;
        bus.readM1 = 1'b1;
        bus.address1 = 16'h0003;
        repeat (65535) @(posedge Clk);
        #1;
        chk("wrap_ffff", bus.inst_reads, 16'hFFFF);
        @(posedge Clk);
        #1;
        chk("wrap_zero", bus.inst_reads, 16'h0000);
        chk("wrap_data1", bus.data1, m_mem[3]);
        bus.readM1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The parameter list SHALL be: WORD_SIZE, 16, data/address word width; ADDR_BITS, 8, index bits used (array depth 2^ADDR_BITS = 256 words).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 The ports SHALL be as follows:
- Clk  in  1  clock; all state changes on posedge.
- Reset_N  in  1  asynchronous active-low reset.
- readM1  in  1  instruction-port read request.
- address1  in  WORD_SIZE  instruction-port address.
- data1  out  WORD_SIZE  instruction-port read data (registered).
- readM2  in  1  data-port read request.
- writeM2  in  1  data-port write request.
- address2  in  WORD_SIZE  data-port address.
- data2  inout  WORD_SIZE  data-port bidirectional bus.
- load_en  in  1  bench preload strobe.
- load_addr  in  ADDR_BITS  preload index.
- load_data  in  WORD_SIZE  preload value.
- inst_reads  out  WORD_SIZE  count of accepted port-1 reads.
- data_reads  out  WORD_SIZE  count of accepted port-2 reads.
- data_writes  out  WORD_SIZE  count of committed port-2 writes.
- proto_err  out  1  sticky protocol-error flag.

Function
REQ-004 The storage array SHALL be indexed by address[ADDR_BITS-1:0]; upper address bits SHALL be ignored, so addresses alias modulo 256.
REQ-005 Port 1: at a posedge with readM1=1, data1 SHALL load mem[address1[7:0]]; with readM1=0, data1 SHALL hold its value. Latency is 1 cycle.
REQ-006 Port 2 has a 3-state FSM: IDLE, RD, WR, updated at each posedge from {readM2,writeM2}:
- 10 -> RD
- 01 -> WR
- 00 -> IDLE
- 11 -> IDLE plus error
REQ-007 Port 2 read: entering or staying in RD SHALL capture mem[address2[7:0]] into rd2_q, so data appears 1 cycle after the request edge.
REQ-008 data2 SHALL be driven with rd2_q only when state=RD, readM2=1 and writeM2=0, evaluated combinationally; otherwise data2 SHALL be high-impedance. The block SHALL never drive data2 while writeM2=1.
REQ-009 Port 2 write: at a posedge with writeM2=1 and readM2=0, mem[address2[7:0]] SHALL take the data2 value, unless REQ-011 applies.
REQ-010 readM2=1 and writeM2=1 in the same cycle SHALL be illegal. Required behaviour:
- no array change;
- no counter change;
- proto_err set to 1 (sticky);
- state goes to IDLE.
REQ-011 load_en SHALL have priority over a port-2 write in the same cycle:
- mem[load_addr] takes load_data;
- the port-2 write is dropped, not counted, and sets proto_err.
- A load alone SHALL not touch any counter.
REQ-012 A same-cycle port-1 or port-2 read and a write/load to the same index SHALL be read-before-write: the read returns the old contents.
REQ-013 inst_reads, data_reads and data_writes SHALL increment by 1 per accepted access per posedge and SHALL wrap from 16'hFFFF to 0.
REQ-014 readM1 and port-2 accesses SHALL proceed independently in the same cycle. No stalls and no ready handshake SHALL exist, because the requester holds requests stable for a fixed multi-cycle window.

Reset
REQ-015 Reset_N=0 SHALL take effect immediately, independent of Clk, and set:
- data1=0, rd2_q=0;
- state=IDLE, so data2 is high-impedance;
- all counters=0;
- proto_err=0.
REQ-016 Reset SHALL NOT alter array contents. Preloaded program/data SHALL survive reset.
REQ-017 An access in flight when reset asserts SHALL be abandoned: no write commit and no count.
REQ-018 After Reset_N rises, the first posedge SHALL process requests normally.

Verification
REQ-019 Preload and fetch: load mem[0..3]=16'h1001..16'h1004; readM1=1 with address1=0..3 on consecutive cycles -> data1 = 16'h1001..16'h1004, each 1 cycle later; inst_reads=4.
REQ-020 Write then read: writeM2=1, address2=16'h0010, CPU drives 16'hBEEF; next readM2=1 at 16'h0010 -> data2=16'hBEEF one cycle later, high-impedance while writeM2=1; data_writes=1, data_reads=1.
REQ-021 Aliasing and read-before-write: mem[5]=16'h0001; same cycle write 16'h0002 to 16'h0105 and readM1 at 16'h0005 -> data1=16'h0001; next readM1 at 16'h0005 -> data1=16'h0002.
REQ-022 Illegal and priority cases:
- readM2=writeM2=1 at index 7 -> mem[7] unchanged, proto_err=1, counters unchanged.
- load_en to index 9 with a concurrent port-2 write to index 9 -> mem[9]=load_data and data_writes unchanged.
REQ-023 Async reset mid-read: in RD state driving data2, pull Reset_N low between edges -> data2 goes high-impedance and counters and data1 read 0 immediately; array contents remain readable after reset.
REQ-024 Counter wrap: 65536 port-1 reads -> inst_reads returns to 0.
